// File: rtl/dmem_responder.sv
// RV32I data-memory responder: req/ready handshake with WAIT_CYCLES wait states, byte-lane stores,
// sign/zero-extended loads. Define DMEM_CYCLE_CNT_EN to map a free-running cycle counter at CNT_ADDR.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] CNT_ADDR    = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          illegal_c, misalign_c, range_c, acc_err_c;
    logic          resp_entry_c, mem_we_c;
    logic [3:0]    be_c;
    logic [31:0]   wrep_c, word_c, load_c, rdata_c;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;

    assign idx = addr[AW+1:2];

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;

    // Free-running cycle counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    // Access decode: legality, byte enables, lane replication and load extension
    always_comb begin
        illegal_c  = 1'b0;
        misalign_c = 1'b0;
        range_c    = 1'b0;
        be_c       = 4'b0000;
        wrep_c     = wdata;
        load_c     = '0;

        if (we) begin
            illegal_c = !(funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal_c = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        misalign_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        range_c    = (addr >> (AW + 2)) != 32'd0;

        case (funct3[1:0])
            2'b00: begin
                be_c   = 4'b0001 << addr[1:0];
                wrep_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c   = addr[1] ? 4'b1100 : 4'b0011;
                wrep_c = {2{wdata[15:0]}};
            end
            default: begin
                be_c   = 4'b1111;
                wrep_c = wdata;
            end
        endcase

        word_c = mem[idx];
        byte_c = word_c[{addr[1:0], 3'b000} +: 8];
        half_c = addr[1] ? word_c[31:16] : word_c[15:0];

        case (funct3)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b010:  load_c = word_c;
            3'b100:  load_c = {24'd0, byte_c};
            3'b101:  load_c = {16'd0, half_c};
            default: load_c = '0;
        endcase

        acc_err_c = illegal_c | misalign_c | range_c;
        rdata_c   = (we || acc_err_c) ? '0 : load_c;
`ifdef DMEM_CYCLE_CNT_EN
        // Counter address takes priority over the RAM range check; only LW is legal there
        if (addr == CNT_ADDR) begin
            acc_err_c = we || (funct3 != 3'b010);
            rdata_c   = acc_err_c ? '0 : cycle_cnt;
        end
`endif

        resp_entry_c = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (wait_cnt == '0));
        mem_we_c     = resp_entry_c && we && !acc_err_c && !reset;
    end

    // RAM write commits on the edge entering RESP; contents are never reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    mem[idx][8*b +: 8] <= wrep_c[8*b +: 8];
                end
            end
        end
    end

    // Handshake FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            ready <= 1'b0;
            if (resp_entry_c) begin
                state <= RESP;
                ready <= 1'b1;
                err   <= acc_err_c;
                rdata <= rdata_c;
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                    WAIT:    wait_cnt <= wait_cnt - 1'b1;
                    RESP:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RV32I datapath.
- Serves load/store requests driven from the datapath's ALU result (address) and rs2 data.
- Returns extended read data to the datapath's write-back data-memory input.
- Uses a req/ready handshake with a configurable wait-state count, so the core can stall on memory. Stores use byte-lane merging; loads use sign/zero extension by funct3.

Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two.
- WAIT_CYCLES, 0: extra wait cycles between accept and response (0..15).
- CNT_ADDR, 32'hFFFF_FF00: word address of the cycle counter; used only with the optional feature.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  access request; held high until ready
- we  input  1  1 = store, 0 = load
- funct3  input  3  RV32I load/store funct3
- addr  input  32  byte address
- wdata  input  32  store data, taken from the low bits by size
- rdata  output  32  extended load data; valid only while ready=1
- ready  output  1  one-cycle completion pulse
- err  output  1  qualifies ready: misaligned, illegal funct3, or out of range

Behaviour:
- Reset values: state=IDLE, ready=0, err=0, rdata=0, wait counter=0. RAM contents are not cleared.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req=1 accepts the access at that edge.
  - Goes to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else to RESP.
- WAIT:
  - Counter decrements each cycle.
  - Goes to RESP when the counter is 0.
- RESP:
  - ready=1 for exactly one cycle; err and rdata are registered and valid.
  - Next state is always IDLE. req is ignored in RESP.
- Latency: ready is high in cycle T+1+WAIT_CYCLES, where T is the accept cycle. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Requester rules:
  - Must hold we, funct3, addr and wdata stable from accept through the ready cycle.
  - Dropping req mid-access does not cancel it.
- Decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 gives err=1.
- Alignment:
  - Halfword accesses require addr[0]=0.
  - Word accesses require addr[1:0]=0.
  - Violation gives err=1.
- Range: addr >= DEPTH_WORDS*4 gives err=1. Word index is addr[log2(DEPTH_WORDS)+1:2].
- Stores:
  - Byte enables come from size and addr[1:0].
  - wdata byte/halfword is replicated onto the selected lanes.
  - The write commits on the edge entering RESP.
  - On err there is no write.
- Loads:
  - The addressed byte/halfword is right-justified.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - On err, rdata=0.
- Stores return rdata=0.
- Reset asserted during WAIT or RESP-entry: the access is abandoned, no write occurs, the FSM returns to IDLE, ready is not pulsed.
- Simultaneous reset and req: reset wins; the request is not accepted.

Optional Feature:
- Macro: DMEM_CYCLE_CNT_EN.
- Defined:
  - A 32-bit free-running counter is added. It resets to 0, increments every cycle and wraps 0xFFFFFFFF to 0.
  - LW at CNT_ADDR returns the counter value captured on the edge entering RESP, with err=0.
  - Any store or sub-word load at CNT_ADDR gives err=1 with no effect.
  - CNT_ADDR is checked before the range check.
- Undefined: no counter logic; CNT_ADDR is decoded like any other address (out of range by default, so err=1).

Test Plan:
- WAIT_CYCLES=0: SW addr=0x10, wdata=0xDEADBEEF, then LW addr=0x10 -> ready in cycle T+1 for each access, rdata=0xDEADBEEF, err=0.
- SB addr=0x11, wdata=0x000000A5 over word 0xDEADBEEF, then LB 0x11 / LBU 0x11 / LW 0x10 -> 0xFFFFFFA5 / 0x000000A5 / 0xDEADA5EF.
- SH addr=0x12, wdata=0x8001, then LH 0x12 / LHU 0x12 -> 0xFFFF8001 / 0x00008001.
- Error cases: LW 0x13; SH 0x11; funct3=011; LW 0x1000 with DEPTH_WORDS=1024 -> each gives ready=1, err=1, rdata=0, and a follow-up LW shows memory unchanged.
- WAIT_CYCLES=3: LW accepted at cycle 5 -> ready only in cycle 9; reset pulsed in cycle 7 during an SW -> no ready, word unchanged, the next access is served normally.
- DMEM_CYCLE_CNT_EN defined: two LW at 0xFFFFFF00 accepted 10 cycles apart with WAIT_CYCLES=0 -> values differ by exactly 10; SW to 0xFFFFFF00 -> err=1.
